sad_search_ctrl: RTL

- Scheduler that sequences the pipelined SAD datapath over a set of candidate blocks to find the best match (minimum-SAD search).
- Per candidate: selects it via cand_idx, fires the datapath's active-low go pulse, waits a fixed pipeline latency, then samples sad.
- Tracks the minimum SAD and its index, with an optional early exit when a result falls at or below a threshold.
- Sits between the host/search logic and the SAD engine plus its candidate-memory address mux.

---
 rtl/sad_pkg.sv | 15 +
 rtl/sad_min_tracker.sv | 45 ++++
 rtl/sad_search_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared types and defaults for the SAD search controller and the SAD datapath.
package sad_pkg;
    localparam int SAD_W_DEF       = 32;
    localparam int SAD_LATENCY_DEF = 18;

    typedef logic [SAD_W_DEF-1:0] sad_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EVAL,
        ST_DONE
    } state_e;
endpackage

// File: rtl/sad_min_tracker.sv
// Running minimum of SAD results and the index where it was first seen.
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int SAD_W = SAD_W_DEF,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd_en,
    input  logic [SAD_W-1:0] sad,
    input  logic [IDX_W-1:0] idx,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx
);
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    // Strict compare so ties keep the earlier (lower) index.
    always_comb begin
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        if (clr) begin
            best_sad_d = '1;
            best_idx_d = '0;
        end else if (upd_en && (sad < best_sad_q)) begin
            best_sad_d = sad;
            best_idx_d = idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_sad_q <= '1;
            best_idx_q <= '0;
        end else begin
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_sad = best_sad_q;
    assign best_idx = best_idx_q;
endmodule

// File: rtl/sad_search_ctrl.sv
// Minimum-SAD search scheduler: issues one candidate at a time to the SAD datapath,
// waits out its latency, and tracks the best result with optional early exit.
module sad_search_ctrl
    import sad_pkg::*;
#(
    parameter int NUM_CAND    = 8,
    parameter int CAND_W      = $clog2(NUM_CAND),
    parameter int SAD_W       = SAD_W_DEF,
    parameter int SAD_LATENCY = SAD_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              thresh_en,
    input  logic [SAD_W-1:0]  thresh,
    input  logic [SAD_W-1:0]  sad,
    output logic              sad_go,
    output logic [CAND_W-1:0] cand_idx,
    output logic              busy,
    output logic              done,
    output logic [SAD_W-1:0]  best_sad,
    output logic [CAND_W-1:0] best_idx,
    output logic              early_hit
);
    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | sad_go low for the current candidate
    // WAIT  | datapath latency countdown
    // EVAL  | sad valid: compare and choose next step
    // DONE  | one-cycle done pulse, results valid
    localparam int CNT_W = $clog2(SAD_LATENCY);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CAND_W-1:0] cand_idx_q, cand_idx_d;
    logic              sad_go_q, sad_go_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              early_hit_q, early_hit_d;
    logic [SAD_W-1:0]  thresh_q, thresh_d;
    logic              thresh_en_q, thresh_en_d;
    logic              trk_clr, trk_upd;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_idx_d  = cand_idx_q;
        sad_go_d    = 1'b1;
        busy_d      = busy_q;
        done_d      = 1'b0;
        early_hit_d = early_hit_q;
        thresh_d    = thresh_q;
        thresh_en_d = thresh_en_q;
        trk_clr     = 1'b0;
        trk_upd     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    thresh_d    = thresh;
                    thresh_en_d = thresh_en;
                    cand_idx_d  = '0;
                    early_hit_d = 1'b0;
                    trk_clr     = 1'b1;
                    busy_d      = 1'b1;
                    sad_go_d    = 1'b0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(SAD_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                trk_upd = 1'b1;
                if (thresh_en_q && (sad <= thresh_q)) begin
                    early_hit_d = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_DONE;
                end else if (cand_idx_q == CAND_W'(NUM_CAND - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cand_idx_d = cand_idx_q + CAND_W'(1);
                    sad_go_d   = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort discards the search outright, including any EVAL decision this cycle.
        if (abort && (state_q == ST_ISSUE || state_q == ST_WAIT || state_q == ST_EVAL)) begin
            state_d     = ST_IDLE;
            sad_go_d    = 1'b1;
            done_d      = 1'b0;
            busy_d      = 1'b0;
            early_hit_d = 1'b0;
            trk_clr     = 1'b1;
            trk_upd     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_idx_q  <= '0;
            sad_go_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            early_hit_q <= 1'b0;
            thresh_q    <= '0;
            thresh_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_idx_q  <= cand_idx_d;
            sad_go_q    <= sad_go_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            early_hit_q <= early_hit_d;
            thresh_q    <= thresh_d;
            thresh_en_q <= thresh_en_d;
        end
    end

    sad_min_tracker #(
        .SAD_W (SAD_W),
        .IDX_W (CAND_W)
    ) u_min_tracker (
        .clk      (clk),
        .rst      (rst),
        .clr      (trk_clr),
        .upd_en   (trk_upd),
        .sad      (sad),
        .idx      (cand_idx_q),
        .best_sad (best_sad),
        .best_idx (best_idx)
    );

    assign sad_go    = sad_go_q;
    assign cand_idx  = cand_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign early_hit = early_hit_q;
endmodule
